// File: rtl/sync_ram_pkg.sv
// sync_ram_pkg -- shared constants and types for the sync_ram block.
//   SYNC_RAM_DATA_W / SYNC_RAM_ADDR_W / SYNC_RAM_DEPTH : default geometry (256 x 8)
//   SYNC_RAM_PORTS                                      : number of read ports
//   sync_ram_data_t / sync_ram_addr_t                   : word and address types
package sync_ram_pkg;

   localparam int SYNC_RAM_DATA_W = 8;
   localparam int SYNC_RAM_ADDR_W = 8;
   localparam int SYNC_RAM_DEPTH  = 2 ** SYNC_RAM_ADDR_W;
   localparam int SYNC_RAM_PORTS  = 4;

   typedef logic [SYNC_RAM_DATA_W-1:0] sync_ram_data_t;
   typedef logic [SYNC_RAM_ADDR_W-1:0] sync_ram_addr_t;

endpackage : sync_ram_pkg

// File: rtl/sync_ram_rd_port.sv
// sync_ram_rd_port -- one registered read port of sync_ram.
// Holds its output while rd_en is low. With SYNC_RAM_WR_BYPASS_EN defined, a
// write hitting this port's address in the same cycle forwards the new data.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   rd_en      : load enable (chip select AND read enable)
//   mem_data   : array word currently addressed by this port
//   dout       : registered read data
//   wr_hit     : (bypass build only) same-cycle write to this port's address
//   wr_data    : (bypass build only) data being written
module sync_ram_rd_port
   import sync_ram_pkg::*;
#(
   parameter int DATA_W = SYNC_RAM_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_en,
   input  logic [DATA_W-1:0] mem_data,
   output logic [DATA_W-1:0] dout
`ifdef SYNC_RAM_WR_BYPASS_EN
   ,
   input  logic              wr_hit,
   input  logic [DATA_W-1:0] wr_data
`endif
);

   logic [DATA_W-1:0] next_data;

`ifdef SYNC_RAM_WR_BYPASS_EN
   // Write-through: the word being written wins over the stale array contents.
   assign next_data = wr_hit ? wr_data : mem_data;
`else
   // Read-first: the array is sampled before this edge's write lands.
   assign next_data = mem_data;
`endif

   // NOTE: registers use non-blocking assignments so every flop samples
   // pre-edge values, which is what makes read-first behaviour fall out naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout <= '0;
      end else if (rd_en) begin
         dout <= next_data;
      end
   end

endmodule : sync_ram_rd_port

// File: rtl/sync_ram.sv
// sync_ram -- 256 x 8 synchronous RAM, one write port, four registered read ports.
// Optional feature macro: SYNC_RAM_WR_BYPASS_EN (write-through forwarding on a
// same-cycle read/write address match; read-first when undefined).
// Ports:
//   Clk, Rst_n   : clock, asynchronous active-low reset (clears array and outputs)
//   CS           : chip select, gates both write and read
//   WE, RD       : write enable, common read enable
//   dataIn, WA   : write data and address
//   RA_0..RA_3   : read addresses
//   dOut_0..dOut_3 : registered read data
module sync_ram
   import sync_ram_pkg::*;
#(
   parameter int DATA_W = SYNC_RAM_DATA_W,
   parameter int ADDR_W = SYNC_RAM_ADDR_W,
   parameter int DEPTH  = 2 ** ADDR_W
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              CS,
   input  logic              WE,
   input  logic              RD,
   input  logic [DATA_W-1:0] dataIn,
   input  logic [ADDR_W-1:0] WA,
   input  logic [ADDR_W-1:0] RA_0,
   input  logic [ADDR_W-1:0] RA_1,
   input  logic [ADDR_W-1:0] RA_2,
   input  logic [ADDR_W-1:0] RA_3,
   output logic [DATA_W-1:0] dOut_0,
   output logic [DATA_W-1:0] dOut_1,
   output logic [DATA_W-1:0] dOut_2,
   output logic [DATA_W-1:0] dOut_3
);

   logic [DATA_W-1:0] mem  [DEPTH];
   logic [ADDR_W-1:0] ra   [SYNC_RAM_PORTS];
   logic [DATA_W-1:0] dout [SYNC_RAM_PORTS];
   logic              wr_en;
   logic              rd_en;

   assign wr_en = CS & WE;
   assign rd_en = CS & RD;

   assign ra[0] = RA_0;
   assign ra[1] = RA_1;
   assign ra[2] = RA_2;
   assign ra[3] = RA_3;

   assign dOut_0 = dout[0];
   assign dOut_1 = dout[1];
   assign dOut_2 = dout[2];
   assign dOut_3 = dout[3];

   // NOTE: the array sits inside the async reset because reset must clear
   // every word; this forces a flop-based store rather than a RAM macro.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[WA] <= dataIn;
      end
   end

   for (genvar k = 0; k < SYNC_RAM_PORTS; k++) begin : g_port
      sync_ram_rd_port #(
         .DATA_W (DATA_W)
      ) u_port (
         .clk      (Clk),
         .rst_n    (Rst_n),
         .rd_en    (rd_en),
         .mem_data (mem[ra[k]]),
         .dout     (dout[k])
`ifdef SYNC_RAM_WR_BYPASS_EN
         ,
         .wr_hit   (wr_en && (ra[k] == WA)),
         .wr_data  (dataIn)
`endif
      );
   end

endmodule : sync_ram

// File: tb/tb_sync_ram.sv
// tb_sync_ram -- self-checking bench for sync_ram.
// Table of per-cycle vectors plus a hand-written reset sequence; expected read
// data is pushed to a scoreboard queue when a vector is driven and popped after
// the clock edge that produces it.
module tb_sync_ram;
   import sync_ram_pkg::*;

   typedef logic [3:0][SYNC_RAM_DATA_W-1:0] quad_t;

   typedef struct {
      logic           cs;
      logic           we;
      logic           rd;
      sync_ram_addr_t wa;
      sync_ram_data_t din;
      quad_t          ra;
      quad_t          exp;
   } vec_t;

`ifdef SYNC_RAM_WR_BYPASS_EN
   localparam sync_ram_data_t RAW_EXP = 8'h77;
`else
   localparam sync_ram_data_t RAW_EXP = 8'h06;
`endif

   logic           Clk;
   logic           Rst_n;
   logic           CS;
   logic           WE;
   logic           RD;
   sync_ram_data_t dataIn;
   sync_ram_addr_t WA;
   sync_ram_addr_t RA_0, RA_1, RA_2, RA_3;
   sync_ram_data_t dOut_0, dOut_1, dOut_2, dOut_3;

   int    n_checks;
   int    n_fail;
   quad_t sb [$];
   vec_t  vecs [15];

   sync_ram u_dut (
      .Clk    (Clk),
      .Rst_n  (Rst_n),
      .CS     (CS),
      .WE     (WE),
      .RD     (RD),
      .dataIn (dataIn),
      .WA     (WA),
      .RA_0   (RA_0),
      .RA_1   (RA_1),
      .RA_2   (RA_2),
      .RA_3   (RA_3),
      .dOut_0 (dOut_0),
      .dOut_1 (dOut_1),
      .dOut_2 (dOut_2),
      .dOut_3 (dOut_3)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic vec_t mk(input logic cs, input logic we, input logic rd,
                               input sync_ram_addr_t wa, input sync_ram_data_t din,
                               input sync_ram_addr_t r0, input sync_ram_addr_t r1,
                               input sync_ram_addr_t r2, input sync_ram_addr_t r3,
                               input sync_ram_data_t e0, input sync_ram_data_t e1,
                               input sync_ram_data_t e2, input sync_ram_data_t e3);
      vec_t v;
      v.cs  = cs;
      v.we  = we;
      v.rd  = rd;
      v.wa  = wa;
      v.din = din;
      v.ra[0] = r0; v.ra[1] = r1; v.ra[2] = r2; v.ra[3] = r3;
      v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
      return v;
   endfunction

   task automatic check(input string name, input sync_ram_data_t act, input sync_ram_data_t exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
      end
   endtask

   task automatic check_all(input string name, input quad_t exp);
      check($sformatf("%s port0", name), dOut_0, exp[0]);
      check($sformatf("%s port1", name), dOut_1, exp[1]);
      check($sformatf("%s port2", name), dOut_2, exp[2]);
      check($sformatf("%s port3", name), dOut_3, exp[3]);
   endtask

   task automatic drive(input vec_t v);
      CS = v.cs; WE = v.we; RD = v.rd; WA = v.wa; dataIn = v.din;
      RA_0 = v.ra[0]; RA_1 = v.ra[1]; RA_2 = v.ra[2]; RA_3 = v.ra[3];
   endtask

   // Drive one vector, let one edge happen, then compare against the scoreboard.
   task automatic apply(input string name, input vec_t v);
      quad_t e;
      drive(v);
      sb.push_back(v.exp);
      @(posedge Clk);
      #1;
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: scoreboard empty, expected an entry", name);
      end else begin
         e = sb.pop_front();
         check_all(name, e);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;

      // cs we rd  wa    din    | RA 0..3        | expected dOut 0..3
      vecs[0]  = mk(1, 1, 0, 8'd0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
      vecs[1]  = mk(1, 1, 0, 8'd1, 8'h01, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
      vecs[2]  = mk(1, 1, 0, 8'd2, 8'h10, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
      vecs[3]  = mk(1, 1, 0, 8'd3, 8'h06, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
      vecs[4]  = mk(1, 1, 0, 8'd4, 8'h12, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
      // rotating reads
      vecs[5]  = mk(1, 0, 1, 8'd0, 8'h00, 1, 2, 3, 4, 8'h01, 8'h10, 8'h06, 8'h12);
      vecs[6]  = mk(1, 0, 1, 8'd0, 8'h00, 4, 1, 2, 3, 8'h12, 8'h01, 8'h10, 8'h06);
      vecs[7]  = mk(1, 0, 1, 8'd0, 8'h00, 3, 4, 1, 2, 8'h06, 8'h12, 8'h01, 8'h10);
      vecs[8]  = mk(1, 0, 1, 8'd0, 8'h00, 2, 3, 4, 1, 8'h10, 8'h06, 8'h12, 8'h01);
      // RD=0 with new addresses: hold
      vecs[9]  = mk(1, 0, 0, 8'd0, 8'h00, 1, 1, 1, 1, 8'h10, 8'h06, 8'h12, 8'h01);
      // CS=0: write of 0xAA to 5 ignored, read ignored, outputs hold
      vecs[10] = mk(0, 1, 1, 8'd5, 8'hAA, 0, 0, 0, 0, 8'h10, 8'h06, 8'h12, 8'h01);
      vecs[11] = mk(1, 0, 1, 8'd0, 8'h00, 5, 5, 5, 5, 8'h00, 8'h00, 8'h00, 8'h00);
      // all ports on the same address
      vecs[12] = mk(1, 0, 1, 8'd0, 8'h00, 2, 2, 2, 2, 8'h10, 8'h10, 8'h10, 8'h10);
      // read-during-write on address 3
      vecs[13] = mk(1, 1, 1, 8'd3, 8'h77, 3, 0, 1, 2, RAW_EXP, 8'h00, 8'h01, 8'h10);
      vecs[14] = mk(1, 0, 1, 8'd0, 8'h00, 3, 3, 3, 3, 8'h77, 8'h77, 8'h77, 8'h77);

      // Power-on reset.
      Rst_n = 1'b1;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      #2 Rst_n = 1'b0;
      @(posedge Clk);
      #1;
      check_all("por", '0);
      #2 Rst_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         apply($sformatf("vec%0d", i), vecs[i]);
      end

      // Mid-cycle reset: outputs clear at once, and an edge inside reset with
      // write and read requested must leave everything cleared.
      #2 Rst_n = 1'b0;
      #1;
      check_all("rst_async", '0);
      drive(mk(1, 1, 1, 8'd3, 8'h55, 3, 3, 3, 3, 0, 0, 0, 0));
      @(posedge Clk);
      #1;
      check_all("rst_held", '0);
      #2 Rst_n = 1'b1;
      apply("after_rst", mk(1, 0, 1, 8'd0, 8'h00, 3, 4, 1, 2, 8'h00, 8'h00, 8'h00, 8'h00));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_sync_ram
